ucsbece154_imem_arbiter: RTL and testbench
==========================================

UCSBECE154_IMEM_ARBITER -- requirements
Module: ucsbece154_imem_arbiter

Interface
REQ-001 SHALL have parameter BURST_WORDS, default 8, meaning words returned per memory request (demand block plus prefetched block).
REQ-002 SHALL have parameter STARVE_LIMIT, default 3, meaning consecutive demand grants tolerated while prefetch is pending.
REQ-003 SHALL have parameter TIMEOUT, default 63, meaning maximum WAIT cycles before a burst is abandoned.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 dem_req / dem_addr  in  1/32  demand (I-cache miss) request and byte address.
REQ-007 dem_gnt / dem_valid / dem_last  out  1/1/1  grant pulse, word-valid, final-word flag.
REQ-008 pf_req / pf_addr  in  1/32  prefetcher request and byte address.
REQ-009 pf_gnt / pf_valid / pf_last  out  1/1/1  grant pulse, word-valid, final-word flag.
REQ-010 rd_data  out  32  returned word, shared by both requesters and qualified by the *_valid signals.
REQ-011 mem_req / mem_addr  out  1/32  request and address to instruction memory.
REQ-012 mem_data / mem_ready  in  32/1  memory word and its valid strobe.
REQ-013 busy / timeout_err  out  1/1  burst in progress; sticky timeout flag.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT, STREAM.
REQ-015 IDLE: with any request pending, SHALL select a winner, pulse its *_gnt for exactly 1 cycle, latch {addr[31:2],2'b00} and owner, and go to ISSUE.
REQ-016 Selection: demand SHALL win over prefetch, except when starve_cnt==STARVE_LIMIT with pf_req high, in which case prefetch SHALL win.
REQ-017 starve_cnt SHALL increment on each demand grant made while pf_req is high, SHALL clear on any prefetch grant, and SHALL saturate at STARVE_LIMIT.
REQ-018 Requesters SHALL hold req and addr stable until gnt; req low before grant withdraws the request with no side effect.
REQ-019 ISSUE: mem_req SHALL be 1 for exactly one cycle with mem_addr set to the latched address; next state WAIT.
REQ-020 mem_addr SHALL hold the latched address from ISSUE until return to IDLE.
REQ-021 WAIT: on mem_ready SHALL count the word and go to STREAM; otherwise SHALL increment wait_cnt.
REQ-022 When wait_cnt==TIMEOUT SHALL set timeout_err and return to IDLE without asserting any valid.
REQ-023 STREAM: each cycle with mem_ready high SHALL forward mem_data to rd_data with the owner's *_valid high in that same cycle (combinational, 0-cycle latency).
REQ-024 mem_ready low in STREAM SHALL stall: no valid, word count unchanged, no timeout.
REQ-025 On word index BURST_WORDS-1, owner *_last SHALL be 1 with *_valid, and the next state SHALL be IDLE.
REQ-026 Word counter SHALL be $clog2(BURST_WORDS)+1 bits and SHALL clear on every grant.
REQ-027 No preemption: a request arriving during a burst SHALL wait; a grant SHALL be possible in the first IDLE cycle after the last word (1 idle cycle between bursts).
REQ-028 Simultaneous dem_req and pf_req in IDLE SHALL be resolved per REQ-016, with exactly one gnt.
REQ-029 mem_ready in IDLE or ISSUE SHALL be ignored; no valid is asserted.
REQ-030 busy SHALL be 1 in ISSUE, WAIT and STREAM.
REQ-031 The non-owner *_valid and *_last SHALL be 0 at all times.
REQ-032 timeout_err SHALL clear only on reset.

Reset
REQ-033 reset_n low SHALL immediately force IDLE and zero starve_cnt, wait_cnt, word count and timeout_err.
REQ-034 During reset all outputs SHALL be 0, including rd_data and mem_addr.
REQ-035 Reset mid-burst SHALL drop the burst; post-reset stray mem_ready SHALL be ignored per REQ-029.

Structure
REQ-036 Package ucsbece154_mem_pkg SHALL hold the state encoding (2-bit), owner encoding (DEM=0, PF=1) and the BURST_WORDS/TIMEOUT defaults.
REQ-037 Winner selection and starve_cnt SHALL live in sub-module ucsbece154_arb_prio; the FSM, counters and muxing SHALL stay in the top module.

Verification
REQ-038 dem_req=1, dem_addr=0x00010006, memory latency 40 -> dem_gnt at cycle 1, mem_addr=0x00010004, 8 dem_valid words, dem_last on the 8th.
REQ-039 dem_req and pf_req high together, repeated 4 bursts -> grants DEM, DEM, DEM, PF (STARVE_LIMIT=3).
REQ-040 mem_ready deasserted 3 cycles after word 2 -> no valid during the gap, 8 words total, order preserved.
REQ-041 Memory never responds -> timeout_err=1 after 63 WAIT cycles, IDLE, and the next dem_req is granted.
REQ-042 reset_n low during word 4 of a PF burst -> all outputs 0 immediately; leftover mem_ready pulses produce no pf_valid.
REQ-043 pf_req dropped before grant while demand streams -> no pf_gnt, no pf_valid.

Source files
------------

// File: rtl/ucsbece154_mem_pkg.sv
// ----------------------------------------------------------------------------
// ucsbece154_mem_pkg : shared encodings and defaults for the I-memory arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ucsbece154_mem_pkg;

  localparam int BURST_WORDS_DEFAULT  = 8;
  localparam int TIMEOUT_DEFAULT      = 63;
  localparam int STARVE_LIMIT_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_STREAM = 2'd3
  } state_e;

  typedef enum logic {
    OWN_DEM = 1'b0,
    OWN_PF  = 1'b1
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/ucsbece154_arb_prio.sv
// ----------------------------------------------------------------------------
// ucsbece154_arb_prio : demand-first winner selection with prefetch anti-starvation
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ucsbece154_arb_prio
  import ucsbece154_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic arb_en_i,
  input  logic dem_req_i,
  input  logic pf_req_i,
  output logic gnt_o,
  output logic owner_o
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [SW-1:0] starve_q, starve_d;
  logic          starved;

  always_comb begin
    starved  = (starve_q == SW'(STARVE_LIMIT));
    gnt_o    = arb_en_i && (dem_req_i || pf_req_i);
    owner_o  = pf_req_i && (!dem_req_i || starved);
    starve_d = starve_q;
    // Only demand grants that bypass a waiting prefetch count toward starvation.
    if (gnt_o) begin
      if (owner_o) begin
        starve_d = '0;
      end else if (pf_req_i && !starved) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ucsbece154_imem_arbiter.sv
// ----------------------------------------------------------------------------
// ucsbece154_imem_arbiter : burst arbiter between I-cache demand and prefetcher
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ucsbece154_imem_arbiter
  import ucsbece154_mem_pkg::*;
#(
  parameter int BURST_WORDS  = BURST_WORDS_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int TIMEOUT      = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dem_req,
  input  logic [31:0] dem_addr,
  output logic        dem_gnt,
  output logic        dem_valid,
  output logic        dem_last,
  input  logic        pf_req,
  input  logic [31:0] pf_addr,
  output logic        pf_gnt,
  output logic        pf_valid,
  output logic        pf_last,
  output logic [31:0] rd_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_ready,
  output logic        busy,
  output logic        timeout_err
);

  localparam int WCW = $clog2(BURST_WORDS) + 1;
  localparam int TCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e         state_q, state_d;
  owner_e         owner_q, owner_d;
  logic [31:0]    addr_q, addr_d;
  logic [WCW-1:0] word_q, word_d;
  logic [TCW-1:0] wait_q, wait_d;
  logic           terr_q, terr_d;

  logic           arb_en;
  logic           arb_gnt;
  logic           arb_owner;
  logic           beat;
  logic           last;
  logic           unused_addr_bits;

  // Gating with reset_n keeps grants quiet while reset is held.
  assign arb_en           = reset_n && (state_q == ST_IDLE);
  assign unused_addr_bits = ^{dem_addr[1:0], pf_addr[1:0]};

  ucsbece154_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb_prio (
    .clk       (clk),
    .reset_n   (reset_n),
    .arb_en_i  (arb_en),
    .dem_req_i (dem_req),
    .pf_req_i  (pf_req),
    .gnt_o     (arb_gnt),
    .owner_o   (arb_owner)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    word_d  = word_q;
    wait_d  = wait_q;
    terr_d  = terr_q;
    beat    = 1'b0;
    last    = 1'b0;
    mem_req = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_gnt) begin
          owner_d = owner_e'(arb_owner);
          addr_d  = arb_owner ? {pf_addr[31:2], 2'b00} : {dem_addr[31:2], 2'b00};
          word_d  = '0;
          wait_d  = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_req = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // An expired wait wins over a coincident ready so no word leaks out.
        if (wait_q == TCW'(TIMEOUT)) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (mem_ready) begin
          beat = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_STREAM: begin
        beat = mem_ready;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (beat) begin
      last    = (word_q == WCW'(BURST_WORDS - 1));
      word_d  = word_q + 1'b1;
      state_d = last ? ST_IDLE : ST_STREAM;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_DEM;
      addr_q  <= '0;
      word_q  <= '0;
      wait_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      wait_q  <= wait_d;
      terr_q  <= terr_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign dem_gnt     = arb_gnt && !arb_owner;
  assign pf_gnt      = arb_gnt && arb_owner;
  assign dem_valid   = beat && (owner_q == OWN_DEM);
  assign dem_last    = last && (owner_q == OWN_DEM);
  assign pf_valid    = beat && (owner_q == OWN_PF);
  assign pf_last     = last && (owner_q == OWN_PF);
  assign rd_data     = beat ? mem_data : 32'h0;
  assign mem_addr    = busy ? addr_q : 32'h0;
  assign timeout_err = terr_q;

endmodule

`default_nettype wire

// File: tb/tb_ucsbece154_imem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ucsbece154_imem_arbiter : vector table, directed corner cases and random traffic
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ucsbece154_imem_arbiter;

  localparam int BW = 8;
  localparam int SL = 3;
  localparam int TO = 63;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dem_req = 1'b0;
  logic [31:0] dem_addr = 32'h0;
  logic        pf_req = 1'b0;
  logic [31:0] pf_addr = 32'h0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_data = 32'h0;

  logic        dem_gnt, dem_valid, dem_last;
  logic        pf_gnt, pf_valid, pf_last;
  logic [31:0] rd_data, mem_addr;
  logic        mem_req, busy, timeout_err;

  ucsbece154_imem_arbiter #(
    .BURST_WORDS (BW),
    .STARVE_LIMIT(SL),
    .TIMEOUT     (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dem_req    (dem_req),
    .dem_addr   (dem_addr),
    .dem_gnt    (dem_gnt),
    .dem_valid  (dem_valid),
    .dem_last   (dem_last),
    .pf_req     (pf_req),
    .pf_addr    (pf_addr),
    .pf_gnt     (pf_gnt),
    .pf_valid   (pf_valid),
    .pf_last    (pf_last),
    .rd_data    (rd_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level reference: burst in flight, cycles since grant, words received.
  logic        m_active = 1'b0;
  int          m_since  = 0;
  int          m_got    = 0;
  int          m_waited = 0;
  int          m_starve = 0;
  logic        m_own    = 1'b0;
  logic        m_terr   = 1'b0;
  logic [31:0] m_addr   = 32'h0;
  logic        mg_dem   = 1'b0;
  logic        mg_pf    = 1'b0;

  logic        s_dg, s_dv, s_dl, s_pg, s_pv, s_pl, s_mr, s_busy, s_terr;
  logic [31:0] s_ma;
  logic [72:0] s_vec;
  int          n_pv = 0;
  int          n_pg = 0;

  typedef struct {
    logic        dem;
    logic        pf;
    logic [31:0] da;
    logic [31:0] pa;
    int          lat;
    logic        exp_pf;
    logic [31:0] exp_ma;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs are already applied (posedge+1); check at posedge+4, then advance one cycle.
  task automatic tick();
    logic        e_dg, e_dv, e_dl, e_pg, e_pv, e_pl, e_mr, e_busy, e_terr;
    logic [31:0] e_rd, e_ma;
    logic        win_pf, beat, lst, tmo;
    e_dg = 0; e_dv = 0; e_dl = 0; e_pg = 0; e_pv = 0; e_pl = 0; e_mr = 0; e_busy = 0;
    e_rd = 32'h0; e_ma = 32'h0;
    win_pf = 0; beat = 0; lst = 0; tmo = 0;
    #3;
    if (!reset_n) begin
      m_active = 0; m_starve = 0; m_terr = 0;
    end else if (!m_active) begin
      if (dem_req || pf_req) begin
        win_pf = pf_req && (!dem_req || m_starve == SL);
        e_dg = !win_pf;
        e_pg = win_pf;
      end
    end else begin
      e_busy = 1;
      e_ma   = m_addr;
      if (m_since == 0) e_mr = 1;
      else if (m_got == 0 && m_waited == TO) tmo = 1;
      else if (mem_ready) begin
        beat = 1;
        lst  = (m_got == BW - 1);
        e_rd = mem_data;
        if (m_own) begin e_pv = 1; e_pl = lst; end
        else begin e_dv = 1; e_dl = lst; end
      end
    end
    e_terr = m_terr;

    s_dg = dem_gnt; s_dv = dem_valid; s_dl = dem_last;
    s_pg = pf_gnt;  s_pv = pf_valid;  s_pl = pf_last;
    s_mr = mem_req; s_busy = busy; s_terr = timeout_err; s_ma = mem_addr;
    s_vec = {dem_gnt, dem_valid, dem_last, pf_gnt, pf_valid, pf_last,
             mem_req, busy, timeout_err, rd_data, mem_addr};
    chk("cycle", s_vec, {e_dg, e_dv, e_dl, e_pg, e_pv, e_pl, e_mr, e_busy, e_terr, e_rd, e_ma});
    if (s_pv) n_pv++;
    if (s_pg) n_pg++;
    mg_dem = e_dg;
    mg_pf  = e_pg;

    if (reset_n) begin
      if (!m_active && (e_dg || e_pg)) begin
        m_active = 1; m_since = 0; m_got = 0; m_waited = 0; m_own = win_pf;
        m_addr = (win_pf ? pf_addr : dem_addr) & 32'hFFFF_FFFC;
        if (win_pf) m_starve = 0;
        else if (pf_req && m_starve < SL) m_starve++;
      end else if (m_active) begin
        if (m_since == 0) m_since = 1;
        else if (tmo) begin m_terr = 1; m_active = 0; end
        else if (beat) begin m_got++; if (lst) m_active = 0; end
        else if (m_got == 0) m_waited++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Issue cycle (with a stray ready that must be ignored), then lat silent WAIT cycles.
  task automatic issue_wait(input string nm, input logic [31:0] exp_ma, input int lat);
    mem_ready = 1'b1;
    mem_data  = $urandom;
    tick();
    chk({nm, "_issue"}, {s_mr, s_ma}, {1'b1, exp_ma});
    mem_ready = 1'b0;
    repeat (lat) tick();
  endtask

  task automatic stream(input string nm, input int gap_len);
    int words, gap, cyc, lasts, gapv;
    words = 0; gap = 0; cyc = 0; lasts = 0; gapv = 0;
    while (words < BW && cyc < 300) begin
      if (words == 3 && gap < gap_len) begin
        mem_ready = 1'b0;
        gap++;
      end else begin
        mem_ready = 1'b1;
        mem_data  = $urandom;
      end
      tick();
      cyc++;
      if (s_dv || s_pv) words++;
      if (s_dl || s_pl) lasts++;
      if (!mem_ready && (s_dv || s_pv)) gapv++;
    end
    mem_ready = 1'b0;
    chk({nm, "_words"}, 80'(words), 80'(BW));
    chk({nm, "_last"}, 80'(lasts), 80'd1);
    if (gap_len > 0) chk({nm, "_gap"}, 80'(gapv), 80'd0);
  endtask

  initial begin : main
    int k, pv0, pg0;
    vecs[0] = '{1'b1, 1'b0, 32'h0001_0006, 32'h0000_0000, 40, 1'b0, 32'h0001_0004};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'h0000_3003,  0, 1'b0, 32'h0000_2000};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_2107, 32'h0000_3003,  3, 1'b0, 32'h0000_2104};
    vecs[3] = '{1'b1, 1'b1, 32'h8000_0003, 32'h0000_3003,  1, 1'b0, 32'h8000_0000};
    vecs[4] = '{1'b1, 1'b1, 32'h8000_0003, 32'h0000_3003,  5, 1'b1, 32'h0000_3000};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF,  2, 1'b1, 32'hFFFF_FFFC};
    vecs[6] = '{1'b1, 1'b1, 32'h1234_5679, 32'h5555_5555, 10, 1'b0, 32'h1234_5678};

    @(posedge clk);
    #1;
    dem_req = 1'b1;
    tick();
    chk("reset_outputs", 80'(s_vec), 80'd0);
    dem_req = 1'b0;
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      dem_req = vecs[i].dem; dem_addr = vecs[i].da;
      pf_req  = vecs[i].pf;  pf_addr  = vecs[i].pa;
      tick();
      chk($sformatf("vec%0d_gnt", i), {s_dg, s_pg}, vecs[i].exp_pf ? 2'b01 : 2'b10);
      if (vecs[i].exp_pf) pf_req = 1'b0;
      else dem_req = 1'b0;
      issue_wait($sformatf("vec%0d", i), vecs[i].exp_ma, vecs[i].lat);
      stream($sformatf("vec%0d", i), 0);
    end
    dem_req = 1'b0;
    pf_req  = 1'b0;

    // Stall of 3 cycles after word 2.
    dem_req = 1'b1; dem_addr = 32'h0000_0100;
    tick();
    chk("gap_gnt", s_dg, 1'b1);
    dem_req = 1'b0;
    issue_wait("gap", 32'h0000_0100, 4);
    stream("gap", 3);

    // Memory never answers.
    dem_req = 1'b1; dem_addr = 32'h0000_0200;
    tick();
    dem_req = 1'b0;
    mem_ready = 1'b0;
    tick();
    repeat (60) tick();
    chk("tmo_early", s_terr, 1'b0);
    k = 0;
    while (!s_terr && k < 10) begin
      tick();
      k++;
    end
    chk("tmo_set", {s_terr, s_busy}, 2'b10);
    dem_req = 1'b1; dem_addr = 32'h0000_0300;
    tick();
    chk("tmo_regrant", s_dg, 1'b1);
    dem_req = 1'b0;
    issue_wait("tmo", 32'h0000_0300, 2);
    stream("tmo", 0);
    chk("tmo_sticky", s_terr, 1'b1);

    // Reset during word 4 of a prefetch burst.
    pf_req = 1'b1; pf_addr = 32'h0000_4444;
    tick();
    chk("rst_gnt", s_pg, 1'b1);
    pf_req = 1'b0;
    issue_wait("rst", 32'h0000_4444, 1);
    repeat (3) begin
      mem_ready = 1'b1; mem_data = $urandom;
      tick();
    end
    mem_ready = 1'b1; mem_data = $urandom;
    reset_n = 1'b0;
    tick();
    chk("rst_zero", 80'(s_vec), 80'd0);
    pv0 = n_pv;
    tick();
    reset_n = 1'b1;
    repeat (5) begin
      mem_ready = 1'b1; mem_data = $urandom;
      tick();
    end
    mem_ready = 1'b0;
    chk("rst_stray", 80'(n_pv - pv0), 80'd0);

    // Prefetch request withdrawn while demand streams.
    dem_req = 1'b1; dem_addr = 32'h0000_0500;
    pf_req  = 1'b1; pf_addr  = 32'h0000_0600;
    tick();
    chk("wd_gnt", {s_dg, s_pg}, 2'b10);
    dem_req = 1'b0;
    pg0 = n_pg;
    pv0 = n_pv;
    issue_wait("wd", 32'h0000_0500, 5);
    pf_req = 1'b0;
    stream("wd", 0);
    repeat (3) tick();
    chk("wd_nopf", {16'(n_pg - pg0), 16'(n_pv - pv0)}, 32'd0);

    // Random traffic checked cycle by cycle against the reference.
    for (int c = 0; c < 4000; c++) begin
      if (dem_req && mg_dem) dem_req = 1'b0;
      else if (!dem_req && $urandom_range(3) == 0) begin dem_req = 1'b1; dem_addr = $urandom; end
      else if (dem_req && $urandom_range(15) == 0) dem_req = 1'b0;
      if (pf_req && mg_pf) pf_req = 1'b0;
      else if (!pf_req && $urandom_range(3) == 0) begin pf_req = 1'b1; pf_addr = $urandom; end
      else if (pf_req && $urandom_range(15) == 0) pf_req = 1'b0;
      mem_ready = ($urandom_range(9) < 7);
      mem_data  = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
